// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling re-aligned on every start edge, latency 3+HALF_BIT+9*CLKS_PER_BIT clks from the rx fall.
// No backpressure: every good frame overwrites rx_data with a one-cycle rx_valid strobe.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic             rx_meta_q;
  logic             rx_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic bit_end;
  logic half_end;

  assign bit_end  = (cnt_q == CNT_BIT_LAST);
  assign half_end = (cnt_q == CNT_HALF_LAST);

  // Synchroniser resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s_q) state_d = S_START;
      S_START: if (half_end) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:  if (bit_end && (idx_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = rx_s_q ? S_IDLE : S_BREAK;
      // Hold off start detection until a held-low line or break releases.
      S_BREAK: if (rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = '0;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    case (state_q)
      S_START: begin
        if (!half_end) cnt_d = cnt_q + 1'b1;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (rx_s_q) data_d = shift_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    valid_d = (state_q == S_STOP) && bit_end && rx_s_q;
    err_d   = (state_q == S_STOP) && bit_end && !rx_s_q;
    busy_d  = (state_d != S_IDLE);
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = err_q;
  assign rx_busy      = busy_q;

endmodule
